// File: rtl/led_frame_buffer.sv
// Double-buffered 16x16 palette frame store feeding the WS2812 driver.
// Optional FB_AUTOCLEAR_EN: zero the new back buffer automatically after every swap.
module led_frame_buffer #(
  parameter logic [7:0]  BRIGHT    = 8'd4,
  parameter int unsigned CLEAR_LEN = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [3:0]  wr_x,
  input  logic [3:0]  wr_y,
  input  logic [1:0]  wr_pix,
  input  logic        clear_req,
  input  logic        commit,
  input  logic        drv_busy,
  output logic        frame_start,
  input  logic [7:0]  rd_led,
  output logic [23:0] rd_color,
  output logic        front_sel
);

  typedef enum logic [1:0] {IDLE, CLEAR, WAIT_SWAP, SWAP} state_t;

  localparam logic [7:0] CLR_LAST = 8'(CLEAR_LEN - 1);

  state_t     state;
  logic [7:0] clr_ctr;
  logic       commit_pend;

  logic [1:0] mem_a [256];
  logic [1:0] mem_b [256];

  logic       mem_we;
  logic [7:0] mem_addr;
  logic [1:0] mem_data;
  logic [3:0] wr_col;
  logic [1:0] rd_pix;

  // Arrays are held in physical LED order: serpentine mapping is applied on
  // the write side, so the driver's read indexes the front array directly.
  assign wr_col = wr_y[0] ? wr_x : ~wr_x;

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = {wr_y, wr_col};
    mem_data = wr_pix;
    if (state == IDLE && wr_valid && wr_ready) begin
      mem_we = 1'b1;
    end else if (state == CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = clr_ctr;
      mem_data = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_a <= '{default: '0};
      mem_b <= '{default: '0};
    end else if (mem_we) begin
      if (front_sel) mem_a[mem_addr] <= mem_data;
      else           mem_b[mem_addr] <= mem_data;
    end
  end

  assign rd_pix = front_sel ? mem_b[rd_led] : mem_a[rd_led];

  always_comb begin
    rd_color = '0;
    case (rd_pix)
      2'd1:    rd_color = {BRIGHT, BRIGHT, BRIGHT};
      2'd2:    rd_color = {BRIGHT, 8'h00, 8'h00};
      2'd3:    rd_color = {8'h00, BRIGHT, 8'h00};
      default: rd_color = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      clr_ctr     <= '0;
      commit_pend <= 1'b0;
      wr_ready    <= 1'b0;
      frame_start <= 1'b0;
      front_sel   <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          wr_ready <= 1'b1;
          if (clear_req) begin
            state       <= CLEAR;
            clr_ctr     <= '0;
            commit_pend <= commit;
            wr_ready    <= 1'b0;
          end else if (commit) begin
            state    <= WAIT_SWAP;
            wr_ready <= 1'b0;
          end
        end
        CLEAR: begin
          clr_ctr <= clr_ctr + 8'd1;
          if (commit) commit_pend <= 1'b1;
          if (clr_ctr == CLR_LAST) begin
            commit_pend <= 1'b0;
            if (commit_pend || commit) begin
              state <= WAIT_SWAP;
            end else begin
              state    <= IDLE;
              wr_ready <= 1'b1;
            end
          end
        end
        WAIT_SWAP: begin
          if (!drv_busy) state <= SWAP;
        end
        SWAP: begin
          front_sel   <= ~front_sel;
          frame_start <= 1'b1;
`ifdef FB_AUTOCLEAR_EN
          state       <= CLEAR;
          clr_ctr     <= '0;
          commit_pend <= 1'b0;
`else
          state       <= IDLE;
          wr_ready    <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_buffer.sv
// Directed bench for led_frame_buffer: logical-image model, scoreboard of expected
// rd_color per LED pushed at commit time and popped by read sweeps.
module tb_led_frame_buffer;

  logic        clock;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_x;
  logic [3:0]  wr_y;
  logic [1:0]  wr_pix;
  logic        clear_req;
  logic        commit;
  logic        drv_busy;
  logic        frame_start;
  logic [7:0]  rd_led;
  logic [23:0] rd_color;
  logic        front_sel;

  led_frame_buffer dut (
    .clock      (clock),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_pix     (wr_pix),
    .clear_req  (clear_req),
    .commit     (commit),
    .drv_busy   (drv_busy),
    .frame_start(frame_start),
    .rd_led     (rd_led),
    .rd_color   (rd_color),
    .front_sel  (front_sel)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int fs_count = 0;
  int busy_fs  = 0;
  int m_fs     = 0;
  logic m_sel  = 1'b0;

  // model images indexed logically as y*16+x
  logic [1:0]  m_front [256];
  logic [1:0]  m_back  [256];
  logic [31:0] exp_q [$];

  always @(negedge clock) begin
    if (frame_start === 1'b1) fs_count++;
    if (frame_start === 1'b1 && drv_busy === 1'b1) busy_fs++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pal(input logic [1:0] p);
    case (p)
      2'd1:    return 24'h040404;
      2'd2:    return 24'h040000;
      2'd3:    return 24'h000400;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic model_reset();
    m_front = '{default: '0};
    m_back  = '{default: '0};
    m_sel   = 1'b0;
  endtask

  task automatic push_image();
    for (int led = 0; led < 256; led++) begin
      logic [7:0] l;
      logic [3:0] y;
      logic [3:0] x;
      l = 8'(led);
      y = l[7:4];
      x = l[3:0] ^ (y[0] ? 4'h0 : 4'hF);
      exp_q.push_back({l, pal(m_front[{y, x}])});
    end
  endtask

  task automatic model_swap();
    logic [1:0] tmp [256];
    tmp     = m_front;
    m_front = m_back;
`ifdef FB_AUTOCLEAR_EN
    m_back  = '{default: '0};
`else
    m_back  = tmp;
`endif
    m_sel = ~m_sel;
    m_fs++;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (wr_ready !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check(tag, wr_ready, 1'b1);
  endtask

  task automatic do_write(input logic [3:0] x, input logic [3:0] y, input logic [1:0] p);
    wait_ready("write_ready");
    wr_valid = 1'b1; wr_x = x; wr_y = y; wr_pix = p;
    tick();
    wr_valid = 1'b0;
    m_back[{y, x}] = p;
  endtask

  task automatic do_commit(input bit also_clear, input bit with_wr,
                           input logic [3:0] x, input logic [3:0] y, input logic [1:0] p);
    wait_ready("commit_ready");
    commit = 1'b1; clear_req = also_clear;
    wr_valid = with_wr; wr_x = x; wr_y = y; wr_pix = p;
    tick();
    commit = 1'b0; clear_req = 1'b0; wr_valid = 1'b0;
    if (with_wr) m_back[{y, x}] = p;
    if (also_clear) m_back = '{default: '0};
    model_swap();
    push_image();
  endtask

  task automatic wait_frame(input int exp_lat, input string tag);
    int  n = 0;
    int  ready_hi = 0;
    int  lowc;
    bit  seen = 0;
    while (!seen && n < 2000) begin
      tick();
      n++;
      if (frame_start === 1'b1) seen = 1;
      else if (wr_ready !== 1'b0) ready_hi++;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_ready_low"}, ready_hi, 0);
    check({tag, "_front_sel"}, front_sel, m_sel);
    lowc = (wr_ready === 1'b1) ? 0 : 1;
    tick();
    check({tag, "_fs_width"}, frame_start, 1'b0);
    while (wr_ready !== 1'b1 && lowc < 2000) begin
      lowc++;
      tick();
    end
`ifdef FB_AUTOCLEAR_EN
    check({tag, "_post_ready_low"}, lowc, 256);
`else
    check({tag, "_post_ready_low"}, lowc, 0);
`endif
  endtask

  task automatic sweep(input string tag);
    logic [31:0] e;
    for (int led = 0; led < 256; led++) begin
      tick();
      rd_led = 8'(led);
      #2;
      check({tag, "_sb_nonempty"}, exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check($sformatf("%s_rd_color[%0d]", tag, led), rd_color, e[23:0]);
      end
    end
  endtask

  task automatic spot(input logic [7:0] led, input logic [23:0] exp, input string tag);
    rd_led = led;
    #2;
    check(tag, rd_color, exp);
  endtask

  initial begin
    int viol_fs;
    int viol_rdy;
    logic [23:0] exp15;

    reset = 1'b1; wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_pix = '0;
    clear_req = 1'b0; commit = 1'b0; drv_busy = 1'b0; rd_led = '0;
    model_reset();

    // reset state
    tick(); tick(); tick();
    check("reset_wr_ready", wr_ready, 1'b0);
    check("reset_frame_start", frame_start, 1'b0);
    check("reset_front_sel", front_sel, 1'b0);
    reset = 1'b0;
    tick();
    check("post_reset_wr_ready", wr_ready, 1'b1);
    push_image();
    sweep("reset");
    check("reset_no_fs", fs_count, 0);

    // single pixel on even row lands reversed
    do_write(4'd0, 4'd0, 2'd1);
    do_commit(1'b0, 1'b0, '0, '0, '0);
    wait_frame(2, "commit1");
    spot(8'd15, 24'h040404, "even_row_led15");
    spot(8'd0, 24'h000000, "even_row_led0");
    sweep("frame1");

    // odd row is not reversed
    do_write(4'd0, 4'd1, 2'd2);
    do_commit(1'b0, 1'b0, '0, '0, '0);
    wait_frame(2, "commit2");
    spot(8'd16, 24'h040000, "odd_row_led16");
    sweep("frame2");

    // commit without writes shows the frame from two commits ago
    do_commit(1'b0, 1'b0, '0, '0, '0);
    wait_frame(2, "commit3");
`ifdef FB_AUTOCLEAR_EN
    exp15 = 24'h000000;
`else
    exp15 = 24'h040404;
`endif
    spot(8'd15, exp15, "stale_led15");
    sweep("frame3");

    // driver busy holds off the swap
    do_write(4'd5, 4'd7, 2'd3);
    drv_busy = 1'b1;
    do_commit(1'b0, 1'b0, '0, '0, '0);
    viol_fs = 0; viol_rdy = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (frame_start !== 1'b0) viol_fs++;
      if (wr_ready !== 1'b0) viol_rdy++;
    end
    check("busy_no_fs", viol_fs, 0);
    check("busy_ready_low", viol_rdy, 0);
    drv_busy = 1'b0;
    wait_frame(2, "busy_release");
    sweep("frame4");

    // clear_req and commit together after filling the back buffer
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        do_write(4'(x), 4'(y), 2'd3);
    do_commit(1'b1, 1'b0, '0, '0, '0);
    wait_frame(258, "clear_commit");
    sweep("frame5");

    // write in the same cycle as commit lands before the swap
    do_commit(1'b0, 1'b1, 4'd3, 4'd3, 2'd2);
    wait_frame(2, "write_commit");
    spot(8'd51, 24'h040000, "wr_with_commit_led51");
    sweep("frame6");

    // reset during WAIT_SWAP aborts without frame_start
    wait_ready("abort_ready");
    drv_busy = 1'b1;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick(); tick();
    check("abort_reset_front_sel", front_sel, 1'b0);
    check("abort_reset_fs", frame_start, 1'b0);
    reset = 1'b0;
    drv_busy = 1'b0;
    tick(); tick(); tick(); tick();
    check("abort_fs_count", fs_count, m_fs);
    check("abort_front_sel", front_sel, 1'b0);
    model_reset();
    exp_q.delete();
    push_image();
    sweep("abort");

    check("queue_drained", exp_q.size(), 0);
    check("fs_total", fs_count, m_fs);
    check("fs_while_busy", busy_fs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
